// File: rtl/nios_basic_pio_master_if.sv
// Avalon-MM bus between the PIO sequencing master and a PIO slave.
`timescale 1ns/1ps
interface nios_basic_pio_master_if;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_chipselect,
        output avm_write_n,
        output avm_writedata,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_chipselect,
        input  avm_write_n,
        input  avm_writedata,
        output avm_readdata
    );
endinterface

// File: rtl/nios_basic_pio_master.sv
// PIO pattern sequencer: writes a 4-bit pattern to a PIO slave, reads it back,
// flags readback errors, then dwells TICK_DIV cycles before the next write.
//
// state  | meaning
// IDLE   | waiting for start
// WRITE  | single-cycle Avalon write of the working pattern
// READ   | single-cycle Avalon read, readdata captured at end of cycle
// CHECK  | compare readback, advance pattern and step count
// WAIT   | dwell TICK_DIV cycles before the next write
`timescale 1ns/1ps
module nios_basic_pio_master #(
    parameter logic [31:0] TICK_DIV = 32'd50000000
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic                           stop,
    input  logic [1:0]                     mode,
    input  logic [7:0]                     steps,
    nios_basic_pio_master_if.master        avm,
    output logic                           busy,
    output logic                           done,
    output logic                           mismatch,
    output logic [7:0]                     err_count,
    output logic [3:0]                     pattern
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    localparam logic [31:0] TICK_LAST = TICK_DIV - 32'd1;

    logic [2:0]  state, state_nx;
    logic [1:0]  mode_q;
    logic [7:0]  step_cnt;
    logic        run_forever;
    logic        stop_pend;
    logic [3:0]  work, work_nx;
    logic [31:0] rd_q;
    logic [31:0] tick_cnt;

    logic accept, rd_err, last_step, abort_chk;

    assign accept    = (state == S_IDLE) && start && !stop;
    assign rd_err    = (rd_q[3:0] != pattern) || (rd_q[31:4] != 28'd0);
    assign last_step = !run_forever && (step_cnt == 8'd1);
    assign abort_chk = stop || stop_pend;

    // Next-state decode; a stop seen during WRITE/READ is only acted on in CHECK.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = S_WRITE;
            S_WRITE: state_nx = S_READ;
            S_READ:  state_nx = S_CHECK;
            S_CHECK: state_nx = (abort_chk || last_step) ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (stop)                       state_nx = S_IDLE;
                else if (tick_cnt == TICK_LAST) state_nx = S_WRITE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Working pattern: seeded on accepted start, advanced once per CHECK.
    always_comb begin
        work_nx = work;
        if (accept) begin
            case (mode)
                2'b00:   work_nx = 4'b0000;
                2'b01:   work_nx = 4'b0001;
                2'b10:   work_nx = 4'b0101;
                default: work_nx = 4'b1010;
            endcase
        end else if (state == S_CHECK) begin
            case (mode_q)
                2'b00:   work_nx = work + 4'd1;
                2'b01:   work_nx = {work[2:0], work[3]};
                2'b10:   work_nx = ~work;
                default: work_nx = work;
            endcase
        end
    end

    // Sequencer state, latched configuration, step/tick counters, readback capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            work        <= 4'd0;
            mode_q      <= 2'd0;
            step_cnt    <= 8'd0;
            run_forever <= 1'b0;
            stop_pend   <= 1'b0;
            rd_q        <= 32'd0;
            tick_cnt    <= 32'd0;
        end else begin
            state <= state_nx;
            work  <= work_nx;
            if (accept) begin
                mode_q      <= mode;
                step_cnt    <= steps;
                run_forever <= (steps == 8'd0);
                stop_pend   <= 1'b0;
            end
            if (((state == S_WRITE) || (state == S_READ)) && stop)
                stop_pend <= 1'b1;
            if (state == S_READ)
                rd_q <= avm.avm_readdata;
            if ((state == S_CHECK) && !run_forever && (step_cnt != 8'd0))
                step_cnt <= step_cnt - 8'd1;
            if (state == S_CHECK)
                tick_cnt <= 32'd0;
            else if (state == S_WAIT)
                tick_cnt <= tick_cnt + 32'd1;
        end
    end

    // Registered outputs, driven from the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avm.avm_address    <= 2'd0;
            avm.avm_chipselect <= 1'b0;
            avm.avm_write_n    <= 1'b1;
            avm.avm_writedata  <= 32'd0;
            busy               <= 1'b0;
            done               <= 1'b0;
            mismatch           <= 1'b0;
            err_count          <= 8'd0;
            pattern            <= 4'd0;
        end else begin
            avm.avm_address    <= 2'd0;
            avm.avm_chipselect <= (state_nx == S_WRITE) || (state_nx == S_READ);
            avm.avm_write_n    <= (state_nx != S_WRITE);
            avm.avm_writedata  <= (state_nx == S_WRITE) ? {28'd0, work_nx} : 32'd0;
            busy               <= (state_nx != S_IDLE);
            done               <= (state == S_CHECK) && (state_nx == S_IDLE) && !abort_chk;
            if (accept) begin
                mismatch  <= 1'b0;
                err_count <= 8'd0;
            end else if ((state == S_CHECK) && rd_err) begin
                mismatch <= 1'b1;
                if (err_count != 8'hff)
                    err_count <= err_count + 8'd1;
            end
            if (state_nx == S_WRITE)
                pattern <= work_nx;
        end
    end

endmodule

// File: tb/tb_nios_basic_pio_master.sv
`timescale 1ns/1ps
module tb_nios_basic_pio_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_a = 1'b0, stop_a = 1'b0, start_b = 1'b0, stop_b = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  steps = 8'd0;
    logic        force_a = 1'b0;
    logic [31:0] pio_a = 32'd0;

    logic        busy_a, done_a, mm_a, busy_b, done_b, mm_b;
    logic [7:0]  err_a, err_b;
    logic [3:0]  pat_a, pat_b;

    int errors = 0, checks = 0, cyc = 0;
    int done_cnt_a = 0, done_cnt_b = 0, wr_cnt_b = 0;
    logic [31:0] wr_dat[$];
    int          wr_cyc[$];

    nios_basic_pio_master_if bus_a ();
    nios_basic_pio_master_if bus_b ();

    assign bus_a.avm_readdata = force_a ? 32'h10 : pio_a;
    assign bus_b.avm_readdata = 32'h10;

    nios_basic_pio_master #(.TICK_DIV(32'd4)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .stop(stop_a),
        .mode(mode), .steps(steps), .avm(bus_a),
        .busy(busy_a), .done(done_a), .mismatch(mm_a),
        .err_count(err_a), .pattern(pat_a)
    );

    nios_basic_pio_master #(.TICK_DIV(32'd2)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .stop(stop_b),
        .mode(mode), .steps(steps), .avm(bus_b),
        .busy(busy_b), .done(done_b), .mismatch(mm_b),
        .err_count(err_b), .pattern(pat_b)
    );

    always #5 clk = ~clk;

    // ideal PIO slave register for dut_a plus cycle counter
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus_a.avm_chipselect && !bus_a.avm_write_n)
            pio_a <= bus_a.avm_writedata;
    end

    // bus and done monitors
    always @(negedge clk) begin
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
        if (bus_a.avm_chipselect && !bus_a.avm_write_n) begin
            wr_dat.push_back(bus_a.avm_writedata);
            wr_cyc.push_back(cyc);
        end
        if (bus_b.avm_chipselect && !bus_b.avm_write_n) wr_cnt_b++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic go_a(input logic [1:0] m, input logic [7:0] s);
        mode = m;
        steps = s;
        wr_dat.delete();
        wr_cyc.delete();
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
    endtask

    task automatic wait_idle_a(input int budget);
        int n;
        n = 0;
        while (busy_a && n < budget) begin
            tick(1);
            n++;
        end
        check("idle_timeout_a", {31'd0, busy_a}, 32'd0);
    endtask

    initial begin
        // reset values
        tick(3);
        check("rst_cs",   {31'd0, bus_a.avm_chipselect}, 32'd0);
        check("rst_wn",   {31'd0, bus_a.avm_write_n}, 32'd1);
        check("rst_addr", {30'd0, bus_a.avm_address}, 32'd0);
        check("rst_wd",   bus_a.avm_writedata, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_mm",   {31'd0, mm_a}, 32'd0);
        check("rst_err",  {24'd0, err_a}, 32'd0);
        check("rst_pat",  {28'd0, pat_a}, 32'd0);
        reset_n = 1'b1;
        tick(2);
        check("post_rst_busy", {31'd0, busy_a}, 32'd0);

        // count-up, 3 steps, 7-cycle write period
        done_cnt_a = 0;
        go_a(2'b00, 8'd3);
        check("cu_busy", {31'd0, busy_a}, 32'd1);
        wait_idle_a(100);
        tick(3);
        check("cu_done_cnt", done_cnt_a, 32'd1);
        check("cu_mm",       {31'd0, mm_a}, 32'd0);
        check("cu_pat",      {28'd0, pat_a}, 32'd2);
        check("cu_nwr",      wr_dat.size(), 32'd3);
        check("cu_w0",       wr_dat[0], 32'd0);
        check("cu_w1",       wr_dat[1], 32'd1);
        check("cu_w2",       wr_dat[2], 32'd2);
        check("cu_gap01",    wr_cyc[1] - wr_cyc[0], 32'd7);
        check("cu_gap12",    wr_cyc[2] - wr_cyc[1], 32'd7);

        // walking one with rotate wrap
        go_a(2'b01, 8'd5);
        wait_idle_a(100);
        tick(2);
        check("wo_nwr", wr_dat.size(), 32'd5);
        check("wo_w0", wr_dat[0], 32'h1);
        check("wo_w1", wr_dat[1], 32'h2);
        check("wo_w2", wr_dat[2], 32'h4);
        check("wo_w3", wr_dat[3], 32'h8);
        check("wo_w4", wr_dat[4], 32'h1);

        // alternate
        go_a(2'b10, 8'd3);
        wait_idle_a(100);
        tick(2);
        check("alt_nwr", wr_dat.size(), 32'd3);
        check("alt_w0", wr_dat[0], 32'h5);
        check("alt_w1", wr_dat[1], 32'ha);
        check("alt_w2", wr_dat[2], 32'h5);

        // forced readback error, hold mode
        force_a = 1'b1;
        done_cnt_a = 0;
        go_a(2'b11, 8'd2);
        wait_idle_a(100);
        tick(5);
        check("fe_mm",   {31'd0, mm_a}, 32'd1);
        check("fe_err",  {24'd0, err_a}, 32'd2);
        check("fe_pat",  {28'd0, pat_a}, 32'ha);
        check("fe_done", done_cnt_a, 32'd1);
        force_a = 1'b0;
        go_a(2'b00, 8'd1);
        check("clr_mm",  {31'd0, mm_a}, 32'd0);
        check("clr_err", {24'd0, err_a}, 32'd0);
        wait_idle_a(100);

        // stop during WRITE: pair completes, no done
        tick(2);
        done_cnt_a = 0;
        go_a(2'b00, 8'd5);
        check("sw_wr_cs", {31'd0, bus_a.avm_chipselect}, 32'd1);
        check("sw_wr_wn", {31'd0, bus_a.avm_write_n}, 32'd0);
        stop_a = 1'b1;
        tick(1);
        stop_a = 1'b0;
        check("sw_rd_cs", {31'd0, bus_a.avm_chipselect}, 32'd1);
        check("sw_rd_wn", {31'd0, bus_a.avm_write_n}, 32'd1);
        tick(1);
        check("sw_chk_cs",   {31'd0, bus_a.avm_chipselect}, 32'd0);
        check("sw_chk_busy", {31'd0, busy_a}, 32'd1);
        tick(1);
        check("sw_idle_busy", {31'd0, busy_a}, 32'd0);
        tick(3);
        check("sw_done_cnt", done_cnt_a, 32'd0);
        check("sw_nwr",      wr_dat.size(), 32'd1);

        // start together with stop in IDLE is ignored
        wr_dat.delete();
        start_a = 1'b1;
        stop_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        stop_a = 1'b0;
        tick(3);
        check("ss_busy", {31'd0, busy_a}, 32'd0);
        check("ss_nwr",  wr_dat.size(), 32'd0);

        // reset during READ
        go_a(2'b00, 8'd3);
        tick(1);
        check("rr_rd_cs", {31'd0, bus_a.avm_chipselect}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rr_cs",   {31'd0, bus_a.avm_chipselect}, 32'd0);
        check("rr_wn",   {31'd0, bus_a.avm_write_n}, 32'd1);
        check("rr_busy", {31'd0, busy_a}, 32'd0);
        check("rr_pat",  {28'd0, pat_a}, 32'd0);
        tick(1);
        reset_n = 1'b1;
        wr_dat.delete();
        tick(12);
        check("rr_quiet_busy", {31'd0, busy_a}, 32'd0);
        check("rr_quiet_nwr",  wr_dat.size(), 32'd0);

        // err_count saturation on run-until-stop, then stop in WAIT
        mode = 2'b00;
        steps = 8'd0;
        wr_cnt_b = 0;
        done_cnt_b = 0;
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        begin
            int n;
            n = 0;
            while (wr_cnt_b < 300 && n < 3000) begin
                tick(1);
                n++;
            end
            check("sat_timeout", {31'd0, (wr_cnt_b >= 300)}, 32'd1);
            n = 0;
            while (!(bus_b.avm_chipselect && bus_b.avm_write_n) && n < 20) begin
                tick(1);
                n++;
            end
            check("sat_read_seen", {31'd0, bus_b.avm_chipselect}, 32'd1);
        end
        tick(2);
        check("sat_wait_busy", {31'd0, busy_b}, 32'd1);
        check("sat_wait_cs",   {31'd0, bus_b.avm_chipselect}, 32'd0);
        stop_b = 1'b1;
        tick(1);
        stop_b = 1'b0;
        check("sat_stop_busy", {31'd0, busy_b}, 32'd0);
        check("sat_stop_done", {31'd0, done_b}, 32'd0);
        check("sat_err",       {24'd0, err_b}, 32'd255);
        check("sat_mm",        {31'd0, mm_b}, 32'd1);
        tick(3);
        check("sat_done_cnt",  done_cnt_b, 32'd0);
        check("sat_err_keep",  {24'd0, err_b}, 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nios_basic_pio_master.md
NIOS_BASIC_PIO_MASTER -- requirements
Module: nios_basic_pio_master

Interface
REQ-001 Parameter TICK_DIV, default 50000000, WAIT_TICK dwell in clk cycles between pattern writes; legal range 1..2^32-1.
REQ-002 Port clk  input  1  system clock; all logic on rising edge.
REQ-003 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 Port start  input  1  one-cycle request to begin a sequence; sampled only in IDLE.
REQ-005 Port stop  input  1  abort request; sampled in every non-IDLE state.
REQ-006 Port mode  input  2  pattern mode, latched at start: 00 count-up, 01 walking-one, 10 alternate, 11 hold.
REQ-007 Port steps  input  8  number of writes, latched at start; 0 = run until stop.
REQ-008 Port avm_address  output  2  Avalon-MM address to the PIO slave; always 0.
REQ-009 Port avm_chipselect  output  1  Avalon-MM chipselect.
REQ-010 Port avm_write_n  output  1  Avalon-MM write strobe, active-low.
REQ-011 Port avm_writedata  output  32  Avalon-MM write data.
REQ-012 Port avm_readdata  input  32  Avalon-MM read data; combinational from slave, valid in the same cycle as chipselect.
REQ-013 Port busy  output  1  high in every state except IDLE.
REQ-014 Port done  output  1  one-cycle pulse on natural sequence completion.
REQ-015 Port mismatch  output  1  sticky readback-error flag.
REQ-016 Port err_count  output  8  saturating readback-error count.
REQ-017 Port pattern  output  4  pattern most recently written.

Function
REQ-018 FSM states: IDLE, WRITE, READ, CHECK, WAIT_TICK; all outputs registered.
REQ-019 IDLE: start=1 and stop=0 -> WRITE next cycle; mode and steps latched; mismatch and err_count cleared; working pattern loaded with seed (00:0000, 01:0001, 10:0101, 11:1010).
REQ-020 IDLE: start=1 with stop=1 -> stay IDLE; start ignored in all other states.
REQ-021 WRITE, exactly one cycle: avm_chipselect=1, avm_write_n=0, avm_address=0, avm_writedata={28'b0, working pattern}; pattern output updated to the working pattern in the same cycle; -> READ.
REQ-022 READ, exactly one cycle: avm_chipselect=1, avm_write_n=1, avm_address=0; avm_readdata captured at end of cycle; -> CHECK.
REQ-023 Outside WRITE/READ: avm_chipselect=0, avm_write_n=1, avm_writedata=0.
REQ-024 CHECK: error when captured[3:0] != pattern or captured[31:4] != 0; on error mismatch<=1 and err_count increments, holding at 255.
REQ-025 CHECK: working pattern advances modulo 16 (00:+1 with 1111->0000 wrap; 01:rotate left, 1000->0001; 10:invert all bits; 11:unchanged).
REQ-026 CHECK: step counter decrements when steps!=0; at count 0 -> IDLE with done=1 for one cycle; otherwise -> WAIT_TICK with tick counter cleared.
REQ-027 WAIT_TICK: counter increments each cycle; when counter == TICK_DIV-1 -> WRITE; write-to-write period = TICK_DIV+3 cycles.
REQ-028 stop in WAIT_TICK -> IDLE next cycle; stop in WRITE or READ is recorded and honoured in CHECK, which then goes -> IDLE; an in-progress write/read pair is never truncated.
REQ-029 An abort never asserts done; mismatch, err_count, and pattern are retained after abort or completion until the next accepted start.
REQ-030 steps=0 runs until stop; no step-counter wrap.

Reset
REQ-031 reset_n low asynchronously forces IDLE, avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0, busy=0, done=0, mismatch=0, err_count=0, pattern=0, and clears all internal counters.
REQ-032 Reset asserted mid-transaction drops chipselect immediately; after release the block stays IDLE until a new start.

Verification
REQ-033 TICK_DIV=4, mode=00, steps=3, ideal PIO slave: writes 0,1,2 at cycles separated by 7; done pulses once; busy then low; mismatch=0; pattern=2.
REQ-034 mode=01, steps=5: write sequence 0001,0010,0100,1000,0001 (rotate wrap); mode=10, steps=3: 0101,1010,0101.
REQ-035 Slave readdata forced to 32'h10 during READ, steps=2, mode=11: mismatch=1, err_count=2; next start clears both.
REQ-036 steps=0, TICK_DIV=2, forced error every read for 300 writes: err_count saturates at 255; stop in WAIT_TICK gives IDLE next cycle with no done.
REQ-037 stop asserted during WRITE: READ and CHECK still complete, then IDLE, no done; start and stop together in IDLE: stays IDLE.
REQ-038 reset_n pulsed low during READ: chipselect low asynchronously, all outputs at reset values, no activity until the next start.
